// File: rtl/div_ss_pkg.sv
// Shared definitions for the shift-subtract divider: FSM states and
// two's-complement mode bit positions.
package div_ss_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned TcA = 0;
  localparam int unsigned TcB = 1;

endpackage

// File: rtl/twos_abs.sv
// Conditional two's-complement negate; the most-negative value maps to its
// own bit pattern, which reads correctly as an unsigned magnitude.
module twos_abs #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] w_one;

  assign w_one = {{(W-1){1'b0}}, 1'b1};
  assign y_o   = neg_i ? ((~a_i) + w_one) : a_i;

endmodule

// File: rtl/div_ss.sv
// Restoring shift-subtract divider: one quotient bit per cycle on operand
// magnitudes, with sign fixup of quotient and remainder at the end.
module div_ss
  import div_ss_pkg::*;
#(
  parameter int unsigned ADw = 8,
  parameter int unsigned BDw = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [1:0]     tc_mode_i,
  input  logic           en_pi,
  input  logic [ADw-1:0] a_i,
  input  logic [BDw-1:0] b_i,
  output logic           busy_o,
  output logic           valid_o,
  output logic [ADw-1:0] q_o,
  output logic [BDw-1:0] r_o,
  output logic           dz_o
);

  localparam int unsigned    CntW    = (ADw > 1) ? $clog2(ADw) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(ADw - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  div_state_e r_state, w_state_d;

  logic [BDw:0]    r_pr;
  logic [ADw-1:0]  r_sr;
  logic [BDw-1:0]  r_b;
  logic [BDw-1:0]  r_a_lo;
  logic            r_qneg;
  logic            r_rneg;
  logic            r_dz;
  logic [CntW-1:0] r_cnt;
  logic            r_valid;
  logic [ADw-1:0]  r_q;
  logic [BDw-1:0]  r_r;
  logic            r_dz_o;

  logic           w_accept;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [ADw-1:0] w_a_mag;
  logic [BDw-1:0] w_b_mag;
  logic [BDw:0]   w_shift;
  logic [BDw+1:0] w_trial;
  logic           w_ge;
  logic [BDw:0]   w_pr_step;
  logic [ADw-1:0] w_sr_step;
  logic [ADw-1:0] w_q_fix;
  logic [BDw-1:0] w_r_fix;

  assign w_accept = (r_state == IDLE) && en_pi;
  assign w_a_neg  = tc_mode_i[TcA] & a_i[ADw-1];
  assign w_b_neg  = tc_mode_i[TcB] & b_i[BDw-1];

  twos_abs #(.W(ADw)) u_abs_a (
    .a_i   (a_i),
    .neg_i (w_a_neg),
    .y_o   (w_a_mag)
  );

  twos_abs #(.W(BDw)) u_abs_b (
    .a_i   (b_i),
    .neg_i (w_b_neg),
    .y_o   (w_b_mag)
  );

  // Partial remainder stays below |b| between steps, so its top bit is
  // always clear before the shift and the shifted value fits in BDw+1 bits.
  assign w_shift   = {r_pr[BDw-1:0], r_sr[ADw-1]};
  assign w_trial   = {1'b0, w_shift} - {2'b00, r_b};
  assign w_ge      = ~w_trial[BDw+1];
  assign w_pr_step = w_ge ? w_trial[BDw:0] : w_shift;
  assign w_sr_step = {r_sr[ADw-2:0], w_ge};

  twos_abs #(.W(ADw)) u_fix_q (
    .a_i   (r_sr),
    .neg_i (r_qneg),
    .y_o   (w_q_fix)
  );

  twos_abs #(.W(BDw)) u_fix_r (
    .a_i   (r_pr[BDw-1:0]),
    .neg_i (r_rneg),
    .y_o   (w_r_fix)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (en_pi) w_state_d = CALC;
      CALC:    if (r_cnt == '0) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pr    <= '0;
      r_sr    <= '0;
      r_b     <= '0;
      r_a_lo  <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz_o  <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE);
      if (w_accept) begin
        r_pr   <= '0;
        r_sr   <= w_a_mag;
        r_b    <= w_b_mag;
        r_a_lo <= a_i[BDw-1:0];
        r_qneg <= w_a_neg ^ w_b_neg;
        r_rneg <= w_a_neg;
        r_dz   <= (b_i == '0);
        r_cnt  <= CntInit;
      end else if (r_state == CALC) begin
        r_pr <= w_pr_step;
        r_sr <= w_sr_step;
        if (r_cnt != '0) r_cnt <= r_cnt - CntOne;
      end else if (r_state == DONE) begin
        if (r_dz) begin
          r_q    <= '1;
          r_r    <= r_a_lo;
          r_dz_o <= 1'b1;
        end else begin
          r_q    <= w_q_fix;
          r_r    <= w_r_fix;
          r_dz_o <= 1'b0;
        end
      end
    end
  end

  assign busy_o  = (r_state != IDLE);
  assign valid_o = r_valid;
  assign q_o     = r_q;
  assign r_o     = r_r;
  assign dz_o    = r_dz_o;

endmodule

// File: tb/tb_div_ss.sv
// Directed bench for div_ss (8/8): vector table plus handshake, back-to-back
// and reset-abort sequences.
module tb_div_ss;

  logic       clk_i;
  logic       rst_ni;
  logic [1:0] tc_mode_i;
  logic       en_pi;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       busy_o;
  logic       valid_o;
  logic [7:0] q_o;
  logic [7:0] r_o;
  logic       dz_o;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0] tc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs [10];

  div_ss #(.ADw(8), .BDw(8)) u_dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .tc_mode_i (tc_mode_i),
    .en_pi     (en_pi),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .q_o       (q_o),
    .r_o       (r_o),
    .dz_o      (dz_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Call at a negedge. Returns at the negedge where valid_o is seen (or the
  // bound expires); lat counts negedges, 1 = first one after the start edge.
  task automatic run_op(input logic [1:0] tc, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt);
    tc_mode_i = tc;
    a_i       = a;
    b_i       = b;
    en_pi     = 1'b1;
    @(negedge clk_i);
    en_pi    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (lat <= 30) begin
      if (valid_o) break;
      if (busy_o) busy_cnt++;
      @(negedge clk_i);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int vcount;
    logic [7:0] cap_q;
    logic [7:0] cap_r;
    logic       cap_dz;

    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{2'b00, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{2'b11, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0};
    vecs[2] = '{2'b11, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0};
    vecs[3] = '{2'b11, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0};
    vecs[4] = '{2'b01, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0};
    vecs[5] = '{2'b00, 8'h55,  8'h00,  8'hFF,  8'h55,  1'b1};
    vecs[6] = '{2'b11, 8'hF0,  8'h00,  8'hFF,  8'hF0,  1'b1};
    vecs[7] = '{2'b00, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[8] = '{2'b11, 8'h9C,  8'h07,  8'hF2,  8'hFE,  1'b0};
    vecs[9] = '{2'b10, 8'h64,  8'hF9,  8'hF2,  8'h02,  1'b0};

    rst_ni    = 1'b0;
    en_pi     = 1'b0;
    tc_mode_i = 2'b00;
    a_i       = 8'h00;
    b_i       = 8'h00;
    repeat (2) @(negedge clk_i);
    chk("rst_busy",  {31'd0, busy_o},  32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_q",     {24'd0, q_o},     32'd0);
    chk("rst_r",     {24'd0, r_o},     32'd0);
    chk("rst_dz",    {31'd0, dz_o},    32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].tc, vecs[i].a, vecs[i].b, lat, busy_cnt);
      chk($sformatf("v%0d_lat", i),  lat,      32'd10);
      chk($sformatf("v%0d_busy", i), busy_cnt, 32'd9);
      chk($sformatf("v%0d_q", i),    {24'd0, q_o},  {24'd0, vecs[i].q});
      chk($sformatf("v%0d_r", i),    {24'd0, r_o},  {24'd0, vecs[i].r});
      chk($sformatf("v%0d_dz", i),   {31'd0, dz_o}, {31'd0, vecs[i].dz});
      chk($sformatf("v%0d_bsy_in_valid", i), {31'd0, busy_o}, 32'd0);
      @(negedge clk_i);
      chk($sformatf("v%0d_pulse", i), {31'd0, valid_o}, 32'd0);
      chk($sformatf("v%0d_hold_q", i), {24'd0, q_o}, {24'd0, vecs[i].q});
    end

    // en_pi while busy is ignored; operands change mid-calculation.
    tc_mode_i = 2'b00;
    a_i       = 8'd200;
    b_i       = 8'd7;
    en_pi     = 1'b1;
    @(negedge clk_i);
    en_pi  = 1'b0;
    vcount = 0;
    cap_q  = 8'h00;
    cap_r  = 8'h00;
    cap_dz = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) begin
        en_pi     = 1'b1;
        tc_mode_i = 2'b11;
        a_i       = 8'h55;
        b_i       = 8'h00;
      end
      if (n == 4) en_pi = 1'b0;
      if (valid_o) begin
        vcount++;
        cap_q  = q_o;
        cap_r  = r_o;
        cap_dz = dz_o;
      end
      @(negedge clk_i);
    end
    chk("ign_pulses", vcount, 32'd1);
    chk("ign_q",  {24'd0, cap_q},  32'd28);
    chk("ign_r",  {24'd0, cap_r},  32'd4);
    chk("ign_dz", {31'd0, cap_dz}, 32'd0);

    // Back-to-back: second start driven in the valid_o cycle of the first.
    run_op(2'b00, 8'd100, 8'd10, lat, busy_cnt);
    chk("b2b1_lat", lat, 32'd10);
    chk("b2b1_q", {24'd0, q_o}, 32'd10);
    chk("b2b1_r", {24'd0, r_o}, 32'd0);
    run_op(2'b00, 8'd200, 8'd7, lat, busy_cnt);
    chk("b2b2_lat", lat, 32'd10);
    chk("b2b2_q", {24'd0, q_o}, 32'd28);
    chk("b2b2_r", {24'd0, r_o}, 32'd4);
    @(negedge clk_i);

    // Reset mid-calculation aborts; outputs hold a nonzero result beforehand.
    tc_mode_i = 2'b11;
    a_i       = 8'h9C;
    b_i       = 8'h07;
    en_pi     = 1'b1;
    @(negedge clk_i);
    en_pi = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, busy_o},  32'd0);
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_q",     {24'd0, q_o},     32'd0);
    chk("arst_r",     {24'd0, r_o},     32'd0);
    chk("arst_dz",    {31'd0, dz_o},    32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    vcount = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    chk("arst_no_valid", vcount, 32'd0);
    run_op(2'b11, 8'hF9, 8'h02, lat, busy_cnt);
    chk("post_rst_lat", lat, 32'd10);
    chk("post_rst_q", {24'd0, q_o}, 32'hFD);
    chk("post_rst_r", {24'd0, r_o}, 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ss.md
Name: div_ss

Overview:
Shift-subtract (restoring) integer divider. It is the inverse-direction companion of the shift-accumulate multiplier in the math library.
- Computes quotient and remainder of a_i / b_i, one bit per cycle, for signed or unsigned operands.
- Uses the same enable-pulse / busy / valid handshake as the multiplier.
- Captures operands at start, so inputs need not stay stable during calculation.

Parameters:
- ADw, 8: dividend and quotient width; must be >= BDw.
- BDw, 8: divisor and remainder width; must be >= 2.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- tc_mode_i  input  2  two's-complement select, 1=signed; bit[0] for a_i, bit[1] for b_i; sampled with en_pi
- en_pi  input  1  start pulse; accepted only when busy_o=0
- a_i  input  ADw  dividend, sampled when en_pi accepted
- b_i  input  BDw  divisor, sampled when en_pi accepted
- busy_o  output  1  calculation in progress
- valid_o  output  1  one-cycle result-valid pulse
- q_o  output  ADw  quotient, truncated toward zero
- r_o  output  BDw  remainder, same sign as dividend
- dz_o  output  1  divide-by-zero flag, qualified by valid_o

Behaviour:
- Reset is asynchronous via rst_ni. On reset:
  - all state returns to IDLE;
  - busy_o=0, valid_o=0, q_o=0, r_o=0, dz_o=0;
  - iteration counter=0.
  - Reset mid-calculation aborts it: no valid_o pulse follows.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on en_pi.
  - CALC -> DONE when the iteration counter reaches 0 after the final step.
  - DONE -> IDLE unconditionally.
- Operand capture on the accepting edge (edge 0):
  - a_neg = tc_mode_i[0] & a_i[ADw-1]; b_neg = tc_mode_i[1] & b_i[BDw-1].
  - Store |a| (ADw bits) and |b| (BDw bits) as unsigned magnitudes. The magnitude of the most-negative value is its unsigned bit pattern.
  - Store q_neg = a_neg ^ b_neg, r_neg = a_neg, dz = (b_i==0), and the raw a_i.
  - Clear the partial remainder (BDw+1 bits); load the quotient/dividend shift register with |a|; counter = ADw-1.
- CALC: one restoring step per cycle, ADw steps on edges 1..ADw.
  - Shift {partial remainder, shift register} left by 1.
  - trial = partial remainder - {1'b0, |b|}.
  - If trial is non-negative: partial remainder = trial and the shifted-in quotient LSB = 1; otherwise keep the remainder and shift in 0.
  - Decrement the counter each step.
- DONE (edge ADw+1): register the outputs, pulse valid_o=1 for exactly one cycle, return to IDLE.
  - q_o = q_neg ? -Q : Q.
  - r_o = r_neg ? -R : R, where R is the low BDw bits of the partial remainder.
  - If dz: q_o = all ones, r_o = low BDw bits of raw a_i, dz_o=1; otherwise dz_o=0.
  - q_o, r_o and dz_o hold their values until the next DONE or reset.
- Latency and throughput:
  - valid_o is high in the cycle after edge ADw+1, i.e. ADw+1 cycles after en_pi is sampled.
  - busy_o = (state != IDLE): high for ADw+1 cycles and low in the valid_o cycle.
  - Throughput is ADw+1 cycles per result.
- Back-to-back: en_pi asserted in the same cycle as valid_o is accepted, with no bubble.
- en_pi while busy_o=1 is ignored; the current operation is unaffected.
- Signed overflow: most-negative / -1 yields q_o = most-negative, r_o = 0, dz_o = 0. This falls out of the magnitude algorithm and needs no special case.
- Mixed modes (one operand signed, the other unsigned) are legal and use the same sign rules.

Decomposition:
- Shared math package holds:
  - the state enum typedef div_state_e {IDLE, CALC, DONE};
  - TC mode bit-index constants TcA=0, TcB=1.
- One natural sub-module: twos_abs (parameterised width; conditional two's-complement negate). It is instantiated for operand magnitudes and for quotient/remainder sign fixup.
- The restoring step stays inline.

Test Plan (ADw=BDw=8):
- Unsigned: tc=00, a=200, b=7 -> q_o=28, r_o=4, dz_o=0. valid_o is high exactly 9 cycles after en_pi and busy_o is high for 9 cycles.
- Signed: tc=11, a=0xF9 (-7), b=0x02 -> q_o=0xFD (-3), r_o=0xFF (-1). Also tc=11, a=0x07, b=0xFE -> q_o=0xFD, r_o=0x01.
- Overflow and mixed mode:
  - tc=11, a=0x80, b=0xFF -> q_o=0x80, r_o=0x00, dz_o=0.
  - tc=01, a=0x80, b=0xFF (255) -> q_o=0x00, r_o=0x80.
- Divide by zero: tc=00, a=0x55, b=0 -> q_o=0xFF, r_o=0x55, dz_o=1. Also tc=11, a=0xF0, b=0 -> q_o=0xFF, r_o=0xF0, dz_o=1.
- Handshake:
  - en_pi pulsed at cycle 3 of a busy calculation -> ignored; the first result is correct and there is exactly one valid_o pulse.
  - en_pi in the valid_o cycle -> second result arrives 9 cycles later.
  - Operands changed during busy_o -> result unaffected.
- Reset: rst_ni asserted at cycle 4 of a calculation -> busy_o, valid_o, q_o, r_o, dz_o all 0 immediately, with no valid_o afterwards. A new en_pi after release computes correctly.
